// File: rtl/param_fifo.sv
// param_fifo: parameterised single-clock FIFO with registered read data,
// occupancy count and almost-full/almost-empty thresholds.
// Optional sticky overflow/underflow tracking is built only when the
// macro PARAM_FIFO_ERR_EN is defined; otherwise both flags read as 0.
module param_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             wr_accept;
  logic             rd_accept;

  // Status flags come straight from the registered count.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
  end

  // Accept decisions: a write into a full FIFO is allowed only alongside a
  // read, a read needs data present, and flush overrides both.
  always_comb begin
    wr_accept = wr_en && (!full || rd_en) && !flush;
    rd_accept = rd_en && !empty && !flush;
  end

  // Next-state for pointers, occupancy and the read data register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      data_out_d = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = mem[rd_ptr_q];
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign count    = count_q;
  assign data_out = data_out_q;

`ifdef PARAM_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a clear request beats a new set in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en && full && !rd_en && !flush) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty && !flush) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Error flag registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard testbench for param_fifo (default parameters, DEPTH=16).
// Stimulus pushes expected read data into a queue; a separate monitor
// compares data_out one step after each read the bench expects accepted.
module tb_param_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
`ifdef PARAM_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             flush = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, almost_full, almost_empty;
  logic [4:0]       count;
  logic             overflow, underflow;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             rd_fire = 1'b0;
  logic             ov_m = 1'b0;
  logic             uf_m = 1'b0;

  param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .flush(flush), .err_clr(err_clr), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and update the reference model.
  task automatic applyStimulus(input logic wr, input logic [WIDTH-1:0] d,
                               input logic rd, input logic fl, input logic ec);
    logic full_m, empty_m, wacc, racc;
    @(negedge clk);
    wr_en = wr; data_in = d; rd_en = rd; flush = fl; err_clr = ec;
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    wacc = wr && (!full_m || rd) && !fl;
    racc = rd && !empty_m && !fl;
    if (ERR_EN) begin
      if (ec) begin
        ov_m = 1'b0;
        uf_m = 1'b0;
      end else begin
        if (wr && full_m && !rd && !fl) ov_m = 1'b1;
        if (rd && empty_m && !fl) uf_m = 1'b1;
      end
    end
    rd_fire = racc;
    if (fl) model_q.delete();
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(d);
  endtask

  // Idle one negedge and compare status against a hand-given count.
  task automatic checkFlags(input string tag, input int c);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; rd_fire = 1'b0;
    checkOutput({tag, ".count"}, WIDTH'(count), WIDTH'(c));
    checkOutput({tag, ".full"}, WIDTH'(full), WIDTH'(c == DEPTH));
    checkOutput({tag, ".empty"}, WIDTH'(empty), WIDTH'(c == 0));
    checkOutput({tag, ".almost_full"}, WIDTH'(almost_full), WIDTH'(c >= DEPTH - 2));
    checkOutput({tag, ".almost_empty"}, WIDTH'(almost_empty), WIDTH'(c <= 2));
    checkOutput({tag, ".overflow"}, WIDTH'(overflow), WIDTH'(ov_m));
    checkOutput({tag, ".underflow"}, WIDTH'(underflow), WIDTH'(uf_m));
  endtask

  // Monitor: compare data_out just after every edge carrying an expected read.
  initial forever begin
    @(posedge clk);
    if (rd_fire) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_data: got 0x%0h, expected no read", data_out);
      end else begin
        checkOutput("rd_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    checkFlags("reset", 0);
    checkOutput("reset.data_out", data_out, '0);
    rst_n = 1'b1;

    // Write 0..3, then read each with an idle cycle between
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    checkFlags("w4", 4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    checkFlags("r4", 0);

    // Fill to 16 with 0xA0..0xAF, drop a 17th write, drain
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, WIDTH'(32'hA0 + i), 1'b0, 1'b0, 1'b0);
      if (i == 1) checkFlags("c2", 2);
      if (i == 12) checkFlags("c13", 13);
      if (i == 13) checkFlags("c14", 14);
    end
    checkFlags("full16", 16);
    applyStimulus(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
    checkFlags("ovf", 16);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkFlags("drain", 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkFlags("errclr1", 0);

    // Full with simultaneous read/write, then underflow paths
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    checkFlags("fullrw", 16);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkFlags("drain2", 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkFlags("udf", 0);
    applyStimulus(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
    checkFlags("emptyrw", 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkFlags("errclr2", 0);

    // Wrap-around: three passes of interleaved write/read
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++)
        applyStimulus(1'b1, WIDTH'(32'h100 * (p + 1) + i), 1'b0, 1'b0, 1'b0);
      for (int i = 6; i < 12; i++)
        applyStimulus(1'b1, WIDTH'(32'h100 * (p + 1) + i), 1'b1, 1'b0, 1'b0);
      for (int i = 12; i < 18; i++)
        applyStimulus(1'b1, WIDTH'(32'h100 * (p + 1) + i), 1'b0, 1'b0, 1'b0);
      checkFlags("wrap_fill", 12);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkFlags("wrap_drain", 0);
    end

    // Flush: error flags survive, contents and data_out cleared
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, WIDTH'(32'hC0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hEE, 1'b1, 1'b1, 1'b0);
    checkFlags("flush", 0);
    checkOutput("flush.data_out", data_out, '0);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkFlags("post_flush", 0);

    // Asynchronous reset in the middle of a burst
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h13, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; rd_fire = 1'b0;
    model_q.delete();
    ov_m = 1'b0; uf_m = 1'b0;
    #1;
    checkOutput("async.count", WIDTH'(count), '0);
    checkOutput("async.empty", WIDTH'(empty), WIDTH'(1));
    checkOutput("async.data_out", data_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkFlags("post_reset", 0);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", WIDTH'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
